// File: rtl/fcn_neuron_post.sv
// Post-accumulation stage: bias add, round/ReLU/saturate requantisation, neuron indexing.
// Define FCN_POST_ARGMAX_EN to build the per-layer arg-max (class_id/class_valid).
module fcn_neuron_post #(
  parameter  int ACC_WIDTH   = 32,
  parameter  int BIAS_WIDTH  = 16,
  parameter  int OUT_WIDTH   = 8,
  parameter  int SHIFT       = 7,
  parameter  int NUM_NEURONS = 10,
  localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         layer_start,
  input  logic                         acc_valid,
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  input  logic signed [BIAS_WIDTH-1:0] bias_in,
  output logic        [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  output logic        [IDX_W-1:0]      out_index,
  output logic                         layer_done,
  output logic        [IDX_W-1:0]      class_id,
  output logic                         class_valid
);

  localparam int SUM_W = ACC_WIDTH + 1;
  localparam int RND_W = ACC_WIDTH + 2;
  localparam logic [RND_W-1:0] HALF = RND_W'(1) << (SHIFT - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic        [SUM_W-1:0] acc_ext;
  logic        [SUM_W-1:0] bias_ext;

  assign acc_ext  = {{(SUM_W - ACC_WIDTH){acc_in[ACC_WIDTH-1]}}, acc_in};
  assign bias_ext = {{(SUM_W - BIAS_WIDTH){bias_in[BIAS_WIDTH-1]}}, bias_in};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= acc_valid;
      if (acc_valid) s1_sum <= acc_ext + bias_ext;
    end
  end

  // Requantisation of the S1 sum, registered into S2.
  logic signed [RND_W-1:0] rnd;
  logic signed [RND_W-1:0] r;
  logic        [OUT_WIDTH-1:0] q_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_data = '0;
    rnd    = $signed({s1_sum[SUM_W-1], s1_sum} + HALF);
    r      = rnd >>> SHIFT;
    if (r[RND_W-1])                 q_data = '0;
    else if (|r[RND_W-2:OUT_WIDTH]) q_data = '1;
    else                            q_data = r[OUT_WIDTH-1:0];
  end

  // A layer_start coinciding with an S1->S2 transfer makes that sample index 0.
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_now;
  logic [IDX_W-1:0] idx_inc;

  assign idx_now = layer_start ? '0 : cnt;
  assign idx_inc = (idx_now == LAST) ? '0 : idx_now + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      layer_done <= 1'b0;
      cnt        <= '0;
    end else begin
      out_valid  <= s1_valid;
      layer_done <= s1_valid && (idx_now == LAST);
      if (s1_valid) begin
        out_data  <= q_data;
        out_index <= idx_now;
        cnt       <= idx_inc;
      end else if (layer_start) begin
        cnt <= '0;
      end
    end
  end

`ifdef FCN_POST_ARGMAX_EN
  logic signed [SUM_W-1:0] s2_sum;
  logic signed [SUM_W-1:0] best_sum;
  logic        [IDX_W-1:0] best_idx;
  logic                    take;
  logic signed [SUM_W-1:0] win_sum;
  logic        [IDX_W-1:0] win_idx;

  // Index 0 always seeds; later indices need a strict win so ties keep the lowest index.
  assign take    = (out_index == '0) || (s2_sum > best_sum);
  assign win_sum = take ? s2_sum : best_sum;
  assign win_idx = take ? out_index : best_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_sum      <= '0;
      best_sum    <= '0;
      best_idx    <= '0;
      class_id    <= '0;
      class_valid <= 1'b0;
    end else begin
      if (s1_valid) s2_sum <= s1_sum;
      class_valid <= 1'b0;
      if (out_valid && layer_done) begin
        class_id    <= win_idx;
        class_valid <= 1'b1;
      end
      if (layer_start) begin
        best_sum <= '0;
        best_idx <= '0;
      end else if (out_valid) begin
        best_sum <= win_sum;
        best_idx <= win_idx;
      end
    end
  end
`else
  assign class_id    = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fcn_neuron_post.sv
// Directed bench for fcn_neuron_post: rounding, ReLU/saturation, layers, layer_start, async reset.
`timescale 1ns/1ps
module tb_fcn_neuron_post;

  localparam int IDX_W = 4;

  logic               clk;
  logic               reset;
  logic               layer_start;
  logic               acc_valid;
  logic signed [31:0] acc_in;
  logic signed [15:0] bias_in;
  logic [7:0]         out_data;
  logic               out_valid;
  logic [IDX_W-1:0]   out_index;
  logic               layer_done;
  logic [IDX_W-1:0]   class_id;
  logic               class_valid;

  fcn_neuron_post dut (
    .clk         (clk),
    .reset       (reset),
    .layer_start (layer_start),
    .acc_valid   (acc_valid),
    .acc_in      (acc_in),
    .bias_in     (bias_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .layer_done  (layer_done),
    .class_id    (class_id),
    .class_valid (class_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference requantisation for SHIFT=7, OUT_WIDTH=8.
  function automatic longint requant(input longint s);
    longint r;
    r = (s + 64) >>> 7;
    if (r < 0)   return 0;
    if (r > 255) return 255;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " out_data"},    out_data,    0);
    check({tag, " out_valid"},   out_valid,   0);
    check({tag, " out_index"},   out_index,   0);
    check({tag, " layer_done"},  layer_done,  0);
    check({tag, " class_id"},    class_id,    0);
    check({tag, " class_valid"}, class_valid, 0);
  endtask

  task automatic send_check(input string tag, input int acc, input int bias,
                            input int exp_data, input int exp_idx);
    acc_valid = 1'b1;
    acc_in    = 32'(acc);
    bias_in   = 16'(bias);
    step();
    acc_valid = 1'b0;
    check({tag, " T+1 out_valid"}, out_valid, 0);
    step();
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_data"},  out_data,  exp_data);
    check({tag, " out_index"}, out_index, exp_idx);
  endtask

  longint seq_sum[16];

  // Back-to-back samples; layer_start pulses with the first sample and, if ls>=0,
  // in the cycle sample ls moves into the output stage.
  task automatic run_seq(input string name, input int n, input int ls, input int exp_class);
    int e_idx[16];
    int idx;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || i == ls) idx = 0;
      e_idx[i] = idx;
      idx = (idx == 9) ? 0 : idx + 1;
    end
    for (int c = 0; c <= n + 1; c++) begin
      acc_valid   = (c < n);
      layer_start = (c == 0) || (c == ls + 1);
      if (c < n) begin
        bias_in = 16'(c - 3);
        acc_in  = 32'(seq_sum[c] - longint'(c - 3));
      end
      step();
      layer_start = 1'b0;
      if (c >= 1 && c <= n) begin
        check($sformatf("%s[%0d] out_valid", name, c - 1), out_valid, 1);
        check($sformatf("%s[%0d] out_data", name, c - 1), out_data, requant(seq_sum[c - 1]));
        check($sformatf("%s[%0d] out_index", name, c - 1), out_index, e_idx[c - 1]);
        check($sformatf("%s[%0d] layer_done", name, c - 1), layer_done, (e_idx[c - 1] == 9) ? 1 : 0);
        check($sformatf("%s[%0d] class_valid", name, c - 1), class_valid, 0);
      end
      if (c == n + 1) begin
        check({name, " tail out_valid"}, out_valid, 0);
`ifdef FCN_POST_ARGMAX_EN
        check({name, " class_valid"}, class_valid, 1);
        check({name, " class_id"},    class_id,    exp_class);
`else
        check({name, " class_valid off"}, class_valid, 0);
        check({name, " class_id off"},    class_id,    0);
`endif
      end
    end
    acc_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    layer_start = 1'b0;
    acc_valid   = 1'b0;
    acc_in      = '0;
    bias_in     = '0;
    #12;
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check("idle out_valid", out_valid, 0);

    // Rounding, then hold of out_data/out_index while idle
    send_check("round 1024", 1000, 24, 8, 0);
    send_check("round 1088", 1024, 64, 9, 1);
    step();
    check("hold out_valid", out_valid, 0);
    check("hold out_data",  out_data,  9);
    check("hold out_index", out_index, 1);

    // ReLU and saturation
    send_check("relu -500",  -500,   0, 0,   2);
    send_check("sat 100000", 100000, 0, 255, 3);
    send_check("edge 32576", 32576,  0, 255, 4);

    // Full layer with a tie between indices 3 and 4
    seq_sum = '{5, 9, -3, 40, 40, 2, 0, 1, 7, 6, 0, 0, 0, 0, 0, 0};
    run_seq("full", 10, -1, 3);
    step();
    step();
`ifdef FCN_POST_ARGMAX_EN
    check("class hold id", class_id, 3);
`endif
    check("class hold valid", class_valid, 0);

    // Negative-only layer, maximum at index 6
    seq_sum = '{-10, -9, -8, -7, -6, -5, -1, -4, -3, -2, 0, 0, 0, 0, 0, 0};
    run_seq("neg", 10, -1, 6);

    // layer_start with the 5th output; early 1000 must not survive the clear
    seq_sum = '{3, 1000, 2, 4, 3, -2, 8, 50, 11, -7, 50, 0, 4, 9, 0, 0};
    run_seq("restart", 14, 4, 3);

    // Async reset with samples in flight
    send_check("pre-reset 0", 1000, 0, 8, 0);
    send_check("pre-reset 1", 1000, 0, 8, 1);
    acc_valid = 1'b1;
    acc_in    = 32'sd1000;
    bias_in   = '0;
    step();
    acc_in = 32'sd2000;
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("in reset");
    step();
    check("in reset out_valid e1", out_valid, 0);
    step();
    check("in reset out_valid e2", out_valid, 0);
    acc_valid = 1'b0;
    #3;
    reset = 1'b0;
    step();
    check_all_zero("post reset");
    step();
    check("post reset out_valid 2", out_valid, 0);
    send_check("after reset", 1000, 0, 8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fcn_neuron_post.md
# fcn_neuron_post

Post-accumulation stage for the fully-connected layer. Consumes each neuron's final dot-product from the MAC on `acc_valid` (the MAC's `result_valid`/store cycle) and adds the neuron bias. It then requantises to unsigned 8-bit with rounding, ReLU and saturation, and tags each output with its neuron index. Optionally it tracks the arg-max over a layer and reports the winning class for the MNIST output layer.

## Interface
- `ACC_WIDTH`, 32, width of the signed accumulator input.
- `BIAS_WIDTH`, 16, width of the signed bias input.
- `OUT_WIDTH`, 8, width of the unsigned activation output.
- `SHIFT`, 7, requantisation right-shift. Must be ≥1.
- `NUM_NEURONS`, 10, neurons per layer. Must be ≥2.
- `IDX_W`, `$clog2(NUM_NEURONS)`, index width (derived).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `layer_start` in 1: synchronous clear of the neuron counter and the arg-max state.
- `acc_valid` in 1: accumulator sample strobe.
- `acc_in` in ACC_WIDTH: signed accumulator, sampled when `acc_valid`=1.
- `bias_in` in BIAS_WIDTH: signed bias for the same neuron, sampled with `acc_in`.
- `out_data` out OUT_WIDTH: requantised activation.
- `out_valid` out 1: one-cycle strobe qualifying `out_data`/`out_index`.
- `out_index` out IDX_W: neuron index of `out_data`.
- `layer_done` out 1: pulses with `out_valid` for index NUM_NEURONS-1.
- `class_id` out IDX_W: arg-max index of the last completed layer.
- `class_valid` out 1: one-cycle strobe when `class_id` updates.

## Operation
- **S1 register**
  - `sum = acc_in + sign_extend(bias_in)`.
  - Width is ACC_WIDTH+1, so the addition cannot overflow.
- **S2 register**
  - `r = (sum + 2^(SHIFT-1)) >>> SHIFT`: arithmetic shift, round-half-up.
  - If r<0, `out_data`=0 (ReLU).
  - Else if r>2^OUT_WIDTH-1, `out_data`=2^OUT_WIDTH-1 (saturate).
  - Else `out_data`=r.
  - The full-precision `sum` is also carried into S2 for the arg-max.
- **Neuron counter `cnt`**
  - Advances on each S2 output. `out_index`=`cnt`.
  - Wraps from NUM_NEURONS-1 to 0, with `layer_done`=1 on that output.
- **`layer_start`**
  - Forces `cnt`=0 and clears the arg-max state.
  - If an S2 output emerges in the same cycle, it is index 0 of the new layer and seeds the arg-max.
  - Data already in flight in S1/S2 is not discarded.
- **Arg-max**
  - Compares S2 full-precision `sum`, signed, before ReLU.
  - Index 0 always seeds the maximum.
  - A later index replaces the maximum only if strictly greater, so on a tie the lowest index wins.
- **No backpressure.**
  - One sample may be accepted every cycle, including back-to-back `acc_valid`.
  - Three-stage pipeline state is held per stage; there is no FSM beyond `cnt` and the arg-max registers.

## Timing
- **Output latency:** `acc_valid` at cycle T gives `out_valid`/`out_data`/`out_index` at T+2.
- **Class latency:** `class_valid`/`class_id` at T+3, where T is the `acc_valid` of neuron NUM_NEURONS-1.
- **Hold behaviour:**
  - `class_id` holds until the next `class_valid`.
  - `out_data`/`out_index` hold their last value when `out_valid`=0.
- **Reset values:** all outputs 0 (`out_data`, `out_valid`, `out_index`, `layer_done`, `class_id`, `class_valid`). `cnt`=0, arg-max cleared, pipeline valid bits 0.
- **Reset mid-layer:** in-flight samples are dropped and no `out_valid` is produced for them.
- **Throughput:** 1 sample/cycle sustained.
- **Layer boundary:** `class_valid` of layer k may coincide with `out_valid` of layer k+1 index 0.

## Configuration
- **`FCN_POST_ARGMAX_EN` defined:** arg-max registers and compare logic are built; `class_id`/`class_valid` behave as above.
- **Not defined:** no arg-max logic; `class_id`=0 and `class_valid`=0 permanently. `layer_done` and `out_*` are unchanged.

## Test plan
All scenarios use the default parameters (SHIFT=7).
- **Rounding:** `acc_in`=1000, `bias_in`=24 → T+2 `out_data`=8, `out_index`=0, `out_valid`=1. Then `acc_in`=1024, `bias_in`=64 (sum 1088) → 9.
- **ReLU and saturation:** `acc_in`=-500, `bias_in`=0 → 0. `acc_in`=100000, `bias_in`=0 → 255. `acc_in`=32576, `bias_in`=0 → 255 (r=255, not saturated).
- **Full layer, back-to-back:** ten consecutive `acc_valid` with sums 5,9,-3,40,40,2,0,1,7,6. Expect `out_index` 0..9 on consecutive cycles and `layer_done` with index 9. One cycle later: `class_valid`=1, `class_id`=3 (tie with 4 resolved to the lower index).
- **Negative-only layer:** all ten sums in -10..-1 with index 6 at -1 → every `out_data`=0, `class_id`=6.
- **`layer_start` mid-layer:** assert after 4 outputs, coincident with the 5th output emerging. That output has `out_index`=0, and the next `layer_done` comes 9 outputs later.
- **Async reset:** assert `reset` while 2 samples are in flight → no `out_valid` for them. All outputs read 0 while `reset` is held and 0 in the first cycle after release. `cnt` restarts at 0.
